// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - registered 3-to-8 one-hot decoder with per-code hold time
module onehot_decoder_seq #(
  parameter int CODE_W = 3,
  parameter int OUT_W  = 8,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic [CNT_W-1:0]  code_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state, state_nx;
  logic [HOLD_W-1:0]   cnt, cnt_nx;
  logic [OUT_W-1:0]    out_nx;
  logic                out_valid_nx;
  logic [CNT_W-1:0]    code_cnt_nx;
  logic [OUT_W-1:0]    dec_word;
  logic                accept;

  // A new code may only land when nothing is showing or the current one is in its last cycle.
  assign in_ready = !clear && ((state == IDLE) || (cnt == '0));
  assign accept   = in_valid && in_ready;
  assign dec_word = OUT_W'(1) << in_code;

  // Next-state and next-output logic; clear overrides everything except reset.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    out_nx       = out;
    out_valid_nx = out_valid;
    code_cnt_nx  = code_cnt;
    if (clear) begin
      state_nx     = IDLE;
      cnt_nx       = '0;
      out_nx       = '0;
      out_valid_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nx     = HOLD;
            out_nx       = dec_word;
            out_valid_nx = 1'b1;
            cnt_nx       = in_hold;
            code_cnt_nx  = code_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt_nx = cnt - HOLD_W'(1);
          end else if (accept) begin
            // Back-to-back load: the next code replaces the current one with no idle gap.
            out_nx       = dec_word;
            out_valid_nx = 1'b1;
            cnt_nx       = in_hold;
            code_cnt_nx  = code_cnt + CNT_W'(1);
          end else begin
            state_nx     = IDLE;
            out_nx       = '0;
            out_valid_nx = 1'b0;
          end
        end
        default: begin
          state_nx     = IDLE;
          cnt_nx       = '0;
          out_nx       = '0;
          out_valid_nx = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset drops the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      code_cnt  <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      out       <= out_nx;
      out_valid <= out_valid_nx;
      code_cnt  <= code_cnt_nx;
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb/tb_onehot_decoder_seq.sv - scoreboard bench for onehot_decoder_seq
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_code = '0;
  logic [3:0] in_hold = '0;
  logic [7:0] out;
  logic       out_valid;
  logic [7:0] code_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: display cycles remaining for the current code, and codes accepted.
  int       mdl_rem = 0;
  int       mdl_cnt = 0;
  bit       acc_flag = 1'b0;
  bit [2:0] exp_q[$];

  onehot_decoder_seq dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_hold(in_hold),
    .out(out), .out_valid(out_valid), .code_cnt(code_cnt)
  );

  always #5 clk = ~clk;

  function automatic int encode8(input logic [7:0] w);
    int idx = -1;
    for (int i = 0; i < 8; i++) if (w[i]) idx = i;
    return idx;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model update at each rising edge: each accepted code contributes hold+1 display cycles.
  always @(posedge clk) begin
    acc_flag = 1'b0;
    if (!rst_n) begin
      mdl_rem = 0; mdl_cnt = 0; exp_q.delete();
    end else if (clear) begin
      mdl_rem = 0; exp_q.delete();
    end else if (in_valid && mdl_rem <= 1) begin
      mdl_rem = int'(in_hold) + 1;
      for (int i = 0; i <= int'(in_hold); i++) exp_q.push_back(in_code);
      mdl_cnt++;
      acc_flag = 1'b1;
    end else if (mdl_rem > 0) begin
      mdl_rem--;
    end
  end

  // Monitor: compares the DUT against the scoreboard away from the active edge.
  always @(negedge clk) begin
    bit [2:0]   c;
    logic [7:0] w;
    check("in_ready", in_ready, (!clear && mdl_rem <= 1));
    check("code_cnt", code_cnt, mdl_cnt % 256);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        c = exp_q.pop_front();
        w = 8'd1 << c;
        check("out_word", out, w);
        check("recovered_index", encode8(out), c);
        check("onehot_count", $countones(out), 1);
      end
    end else begin
      check("idle_out_zero", out, 0);
      check("no_gap", exp_q.size(), 0);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Present a code and hold it until the model accepts it; in_valid stays high on return.
  task automatic send(input bit [2:0] c, input bit [3:0] h);
    bit done = 1'b0;
    in_valid = 1'b1; in_code = c; in_hold = h;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc();
      if (acc_flag) done = 1'b1;
    end
    if (!done) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_code_cnt", code_cnt, 0);
    rst_n = 1'b1;
    cyc();

    // 1) single code 0, hold 0
    send(3'd0, 4'd0);
    idle(3);
    check("t1_code_cnt", code_cnt, 1);

    // 2) code 7 held 4 cycles
    send(3'd7, 4'd3);
    idle(6);

    // 3) stream 2,5,3 with hold 1, in_valid held high
    send(3'd2, 4'd1);
    send(3'd5, 4'd1);
    send(3'd3, 4'd1);
    idle(4);
    check("t3_code_cnt", code_cnt, 5);

    // 4) clear during a long hold with a pending code
    send(3'd4, 4'd15);
    idle(3);
    in_valid = 1'b1; in_code = 3'd1; in_hold = 4'd0; clear = 1'b1;
    cyc();
    check("t4_no_accept_on_clear", acc_flag, 0);
    check("t4_out_cleared", out, 0);
    check("t4_out_valid_cleared", out_valid, 0);
    clear = 1'b0;
    send(3'd1, 4'd0);
    idle(3);

    // 5) async reset between edges
    send(3'd3, 4'd10);
    idle(2);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_out", out, 0);
    check("t5_async_out_valid", out_valid, 0);
    check("t5_async_code_cnt", code_cnt, 0);
    mdl_rem = 0; mdl_cnt = 0; exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("t5_ready_after_reset", in_ready, 1);
    cyc();

    // 6) sweep every code, then randomized traffic with occasional clear
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 4'(i % 3));
      if (i % 2 == 1) idle(2);
    end
    idle(4);
    for (int i = 0; i < 120; i++) begin
      send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) begin
        in_valid = 1'b0; clear = 1'b1; cyc(); clear = 1'b0;
      end
    end
    idle(6);

    // counter wrap: keep accepting until the count reaches a multiple of 256
    while (mdl_cnt < 256 || mdl_cnt % 256 != 0) send(3'($urandom_range(0, 7)), 4'd0);
    idle(3);
    check("wrap_code_cnt", code_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
